// File: rtl/pc_sequencer.sv
// Program counter sequencer: start/done handshake, sequential fetch, stall hold,
// absolute branches through an external target LUT, HALT detection and a watchdog.
module pc_sequencer #(
  parameter int             D          = 8,
  parameter logic [D-1:0]   START_PC   = '0,
  parameter int             CW         = 16,
  parameter int             MAX_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_cond,
  input  logic [2:0]    branch_idx,
  input  logic          halt_instr,
  output logic [2:0]    lut_idx,
  output logic          lut_branch,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  pc,
  output logic          run,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Count value seen on the final RUN edge the watchdog allows.
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);

  state_t        state, state_nxt;
  logic [D-1:0]  pc_q, pc_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          to_q, to_nxt;
  logic          taken;

  assign taken      = branch_en & branch_cond;
  assign lut_idx    = branch_idx;
  assign lut_branch = taken & run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= '0;
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
      to_q  <= to_nxt;
    end
  end

  // Stall outranks halt and branch; the watchdog outranks everything in RUN.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
    to_nxt    = to_q;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_PC;
          cnt_nxt   = '0;
          to_nxt    = 1'b0;
        end
      end
      RUN: begin
        cnt_nxt = cnt_q + CW'(1);
        if (cnt_q == WD_LAST) begin
          state_nxt = HALTED;
          to_nxt    = 1'b1;
        end else if (stall) begin
          pc_nxt = pc_q;
        end else if (halt_instr) begin
          state_nxt = HALTED;
        end else if (taken) begin
          pc_nxt = lut_target;
        end else begin
          pc_nxt = pc_q + D'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
        cnt_nxt   = '0;
        to_nxt    = 1'b0;
      end
    endcase
  end

  assign pc        = pc_q;
  assign run       = (state == RUN);
  assign done      = (state == HALTED);
  assign timeout   = to_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer: one instance with default
// parameters, one with a wrapping start address and a 16-cycle watchdog.
module tb_pc_sequencer;

  typedef struct {
    logic        start, stall, ben, bcond;
    logic [2:0]  bidx;
    logic        halt;
    logic        exp_lb;
    logic [2:0]  exp_idx;
    logic [7:0]  exp_pc;
    logic        exp_run, exp_done, exp_to;
    logic [15:0] exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, branch_en, branch_cond, halt_instr;
  logic [2:0]  branch_idx;

  logic [2:0]  lut_idx_a, lut_idx_b;
  logic        lut_branch_a, lut_branch_b;
  logic [7:0]  lut_target_a, lut_target_b;
  logic [7:0]  pc_a, pc_b;
  logic        run_a, run_b, done_a, done_b, timeout_a, timeout_b;
  logic [15:0] cnt_a, cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;

  vec_t vec_a[25];
  vec_t vec_b[20];

  always #5 clk = ~clk;

  function automatic logic [7:0] lut_model(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'd4;
      3'd1:    return 8'd8;
      default: return 8'd0;
    endcase
  endfunction

  assign lut_target_a = lut_model(lut_idx_a);
  assign lut_target_b = lut_model(lut_idx_b);

  pc_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_cond(branch_cond), .branch_idx(branch_idx),
    .halt_instr(halt_instr), .lut_idx(lut_idx_a), .lut_branch(lut_branch_a),
    .lut_target(lut_target_a), .pc(pc_a), .run(run_a), .done(done_a),
    .timeout(timeout_a), .cycle_cnt(cnt_a)
  );

  pc_sequencer #(.D(8), .START_PC(8'hFD), .CW(16), .MAX_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_cond(branch_cond), .branch_idx(branch_idx),
    .halt_instr(halt_instr), .lut_idx(lut_idx_b), .lut_branch(lut_branch_b),
    .lut_target(lut_target_b), .pc(pc_b), .run(run_b), .done(done_b),
    .timeout(timeout_b), .cycle_cnt(cnt_b)
  );

  function automatic vec_t mk(
    input logic st, input logic sl, input logic be, input logic bc,
    input logic [2:0] bi, input logic ht, input logic lb, input logic [2:0] li,
    input logic [7:0] p, input logic r, input logic d, input logic t,
    input logic [15:0] c);
    vec_t v;
    v.start = st; v.stall = sl; v.ben = be; v.bcond = bc; v.bidx = bi; v.halt = ht;
    v.exp_lb = lb; v.exp_idx = li; v.exp_pc = p; v.exp_run = r; v.exp_done = d;
    v.exp_to = t; v.exp_cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (vector %0d): got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start       = v.start;
    stall       = v.stall;
    branch_en   = v.ben;
    branch_cond = v.bcond;
    branch_idx  = v.bidx;
    halt_instr  = v.halt;
  endtask

  // Combinational LUT outputs are checked before the edge, registered state after it.
  task automatic checkOutput(input vec_t v, input bit sel_b, input int idx);
    #1;
    check("lut_branch", idx, sel_b ? lut_branch_b : lut_branch_a, v.exp_lb);
    check("lut_idx",    idx, sel_b ? lut_idx_b    : lut_idx_a,    v.exp_idx);
    @(posedge clk);
    #1;
    check("pc",        idx, sel_b ? pc_b      : pc_a,      v.exp_pc);
    check("run",       idx, sel_b ? run_b     : run_a,     v.exp_run);
    check("done",      idx, sel_b ? done_b    : done_a,    v.exp_done);
    check("timeout",   idx, sel_b ? timeout_b : timeout_a, v.exp_to);
    check("cycle_cnt", idx, sel_b ? cnt_b     : cnt_a,     v.exp_cnt);
  endtask

  initial begin
    //              st sl be bc idx ht | lb idx | pc    run done to cnt
    vec_a[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0,  8'h00, 1, 0, 0, 0);
    vec_a[1]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h01, 1, 0, 0, 1);
    vec_a[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h02, 1, 0, 0, 2);
    vec_a[3]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h03, 1, 0, 0, 3);
    vec_a[4]  = mk(0, 0, 1, 0, 1, 0,  0, 1,  8'h04, 1, 0, 0, 4);
    vec_a[5]  = mk(0, 0, 1, 1, 1, 0,  1, 1,  8'h08, 1, 0, 0, 5);
    vec_a[6]  = mk(0, 0, 1, 1, 0, 0,  1, 0,  8'h04, 1, 0, 0, 6);
    vec_a[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h05, 1, 0, 0, 7);
    vec_a[8]  = mk(1, 1, 1, 1, 1, 1,  1, 1,  8'h05, 1, 0, 0, 8);
    vec_a[9]  = mk(1, 1, 1, 1, 1, 1,  1, 1,  8'h05, 1, 0, 0, 9);
    vec_a[10] = mk(0, 0, 0, 0, 0, 1,  0, 0,  8'h05, 0, 1, 0, 10);
    vec_a[11] = mk(0, 0, 1, 1, 1, 0,  0, 1,  8'h05, 0, 1, 0, 10);
    vec_a[12] = mk(1, 0, 0, 0, 0, 0,  0, 0,  8'h00, 1, 0, 0, 0);
    vec_a[13] = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h01, 1, 0, 0, 1);
    vec_a[14] = mk(0, 0, 1, 1, 0, 0,  1, 0,  8'h04, 1, 0, 0, 2);
    vec_a[15] = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h05, 1, 0, 0, 3);
    vec_a[16] = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h06, 1, 0, 0, 4);
    vec_a[17] = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h07, 1, 0, 0, 5);
    vec_a[18] = mk(0, 0, 1, 1, 1, 1,  1, 1,  8'h07, 0, 1, 0, 6);
    vec_a[19] = mk(1, 0, 0, 0, 0, 0,  0, 0,  8'h00, 1, 0, 0, 0);
    vec_a[20] = mk(1, 0, 0, 0, 0, 0,  0, 0,  8'h01, 1, 0, 0, 1);
    vec_a[21] = mk(1, 0, 0, 0, 0, 0,  0, 0,  8'h02, 1, 0, 0, 2);
    vec_a[22] = mk(0, 0, 1, 1, 0, 0,  1, 0,  8'h04, 1, 0, 0, 3);
    vec_a[23] = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h05, 1, 0, 0, 4);
    vec_a[24] = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h06, 1, 0, 0, 5);

    // Second instance: START_PC=0xFD wraps through 0x00, then a branch loop to 4
    // spins until the 16-cycle watchdog fires on RUN edge 16.
    vec_b[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0,  8'hFD, 1, 0, 0, 0);
    vec_b[1]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'hFE, 1, 0, 0, 1);
    vec_b[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'hFF, 1, 0, 0, 2);
    vec_b[3]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  8'h00, 1, 0, 0, 3);
    for (int k = 4; k <= 15; k++)
      vec_b[k] = mk(0, 0, 1, 1, 0, 0,  1, 0,  8'h04, 1, 0, 0, 16'(k));
    vec_b[16] = mk(0, 0, 1, 1, 0, 0,  1, 0,  8'h04, 0, 1, 1, 16);
    vec_b[17] = mk(0, 0, 1, 1, 0, 0,  0, 0,  8'h04, 0, 1, 1, 16);
    vec_b[18] = mk(1, 0, 0, 0, 0, 0,  0, 0,  8'hFD, 1, 0, 0, 0);
    vec_b[19] = mk(1, 1, 0, 0, 0, 0,  0, 0,  8'hFD, 1, 0, 0, 1);

    rst_n = 1'b0; start = 0; stall = 0; branch_en = 0; branch_cond = 0;
    branch_idx = 3'd0; halt_instr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset pc",      -1, pc_a,      8'h00);
    check("reset run",     -1, run_a,     1'b0);
    check("reset done",    -1, done_a,    1'b0);
    check("reset timeout", -1, timeout_a, 1'b0);
    check("reset cnt",     -1, cnt_a,     16'd0);
    check("reset lut_br",  -1, lut_branch_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vec_a[i]);
      checkOutput(vec_a[i], 1'b0, i);
    end

    // Asynchronous reset between edges while RUN at pc=6 clears state at once.
    @(negedge clk);
    start = 0; branch_en = 0; branch_cond = 0; halt_instr = 0; stall = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async pc",   100, pc_a,   8'h00);
    check("async run",  100, run_a,  1'b0);
    check("async done", 100, done_a, 1'b0);
    check("async cnt",  100, cnt_a,  16'd0);
    @(posedge clk);
    #1;
    check("held pc",    101, pc_a,   8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vec_b[i]);
      checkOutput(vec_b[i], 1'b1, 200 + i);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
